// File: rtl/fpu_pkg.sv
// +--------------------------------------------------------------------------+
// | fpu_pkg : shared FP format constants and result-stage state encoding      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

  localparam int SP_EW = 8;
  localparam int SP_SW = 23;
  localparam int DP_EW = 11;
  localparam int DP_SW = 52;

  localparam logic [SP_EW-1:0] SP_EXP_ONES = '1;
  localparam logic [SP_EW-1:0] SP_EXP_ZERO = '0;
  localparam logic [DP_EW-1:0] DP_EXP_ONES = '1;
  localparam logic [DP_EW-1:0] DP_EXP_ZERO = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/special_case_encode.sv
// +--------------------------------------------------------------------------+
// | special_case_encode : priority packing of sign/exp/mant with specials     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module special_case_encode
  import fpu_pkg::*;
#(
  parameter int W  = 1 + SP_EW + SP_SW,
  parameter int EW = SP_EW,
  parameter int SW = SP_SW
) (
  input  logic          sign_i,
  input  logic [EW:0]   exp_i,
  input  logic [SW-1:0] mant_i,
  input  logic          zero_flag_i,
  input  logic          underflow_i,
  output logic [W-1:0]  word_o,
  output logic          ovf_o,
  output logic          unf_o
);

  logic w_exp_sat;

  // Carry out of the exponent adder or a saturated field both mean infinity.
  assign w_exp_sat = exp_i[EW] | (&exp_i[EW-1:0]);

  always_comb begin
    word_o = {sign_i, exp_i[EW-1:0], mant_i};
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    if (zero_flag_i) begin
      word_o = '0;
    end else if (underflow_i) begin
      word_o = {sign_i, {(W-1){1'b0}}};
      unf_o  = 1'b1;
    end else if (w_exp_sat) begin
      word_o = {sign_i, {EW{1'b1}}, {SW{1'b0}}};
      ovf_o  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/final_result_pack.sv
// +--------------------------------------------------------------------------+
// | final_result_pack : registered IEEE-754 result with valid/ready hold      |
// | optional FPU_STICKY_FLAGS_EN adds clr_flags_i / sticky_flags_o; rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module final_result_pack
  import fpu_pkg::*;
#(
  parameter int W  = 1 + SP_EW + SP_SW,
  parameter int EW = SP_EW,
  parameter int SW = SP_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          sign_i,
  input  logic [EW:0]   exp_i,
  input  logic [SW-1:0] mant_i,
  input  logic          zero_flag_i,
  input  logic          underflow_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic          busy_o,
  output logic [W-1:0]  final_result_ieee_o,
  output logic          overflow_flag_o,
  output logic          underflow_flag_o
`ifdef FPU_STICKY_FLAGS_EN
  ,
  input  logic          clr_flags_i,
  output logic [1:0]    sticky_flags_o
`endif
);

  state_e         state_q;
  state_e         state_d;
  logic [W-1:0]   result_q;
  logic           ovf_q;
  logic           unf_q;
  logic [W-1:0]   w_word;
  logic           w_ovf;
  logic           w_unf;
  logic           w_capture;

  special_case_encode #(
    .W  (W),
    .EW (EW),
    .SW (SW)
  ) u_encode (
    .sign_i      (sign_i),
    .exp_i       (exp_i),
    .mant_i      (mant_i),
    .zero_flag_i (zero_flag_i),
    .underflow_i (underflow_i),
    .word_o      (w_word),
    .ovf_o       (w_ovf),
    .unf_o       (w_unf)
  );

  // A held result blocks new loads until the consumer takes it.
  assign w_capture = load_i & ((state_q == ST_IDLE) | ready_i);

  always_comb begin
    state_d = state_q;
    if (w_capture) begin
      state_d = ST_HOLD;
    end else if ((state_q == ST_HOLD) && ready_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_capture) begin
        result_q <= w_word;
        ovf_q    <= w_ovf;
        unf_q    <= w_unf;
      end
    end
  end

  assign valid_o             = (state_q == ST_HOLD);
  assign busy_o              = (state_q == ST_HOLD) & ~ready_i;
  assign final_result_ieee_o = result_q;
  assign overflow_flag_o     = ovf_q;
  assign underflow_flag_o    = unf_q;

`ifdef FPU_STICKY_FLAGS_EN
  logic [1:0] sticky_q;

  // A same-cycle capture re-sets its own bits after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 2'b00;
    end else if (w_capture) begin
      sticky_q <= (clr_flags_i ? 2'b00 : sticky_q) | {w_ovf, w_unf};
    end else if (clr_flags_i) begin
      sticky_q <= 2'b00;
    end
  end

  assign sticky_flags_o = sticky_q;
`endif

endmodule

`default_nettype wire
